instr_sequencer: RTL and testbench



---
 rtl/instr_sequencer.sv | 142 ++++++++++++++
 tb/tb_instr_sequencer.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_sequencer.sv
// instr_sequencer: fetches instruction words from a 1-cycle-latency synchronous
// memory and hands each one to the processor with a one-cycle run pulse. It
// then waits for proc_done before advancing the PC by jump, increment, wrap
// or halt.
// Optional feature: define INSTR_SEQUENCER_RETCNT_EN to add the ret_cnt output,
// a saturating 16-bit count of completed instructions.
// Timing: the IDLE cycle that accepts enable is followed by FETCH, then LATCH,
// and run is high in the third cycle after that IDLE cycle (the ISSUE cycle).
module instr_sequencer #(
  parameter int ADDR_W    = 5,
  parameter int DATA_W    = 16,
  parameter int LAST_ADDR = 2**ADDR_W-1,
  parameter int WRAP      = 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_q,
  output logic [DATA_W-1:0] instr,
  output logic              run,
  input  logic              proc_done,
  input  logic              jump_en,
  input  logic [ADDR_W-1:0] jump_addr,
  output logic [ADDR_W-1:0] pc,
  output logic              halted
`ifdef INSTR_SEQUENCER_RETCNT_EN
  ,
  output logic [15:0]       ret_cnt
`endif
);

  localparam logic [ADDR_W-1:0] LAST_PC = ADDR_W'(LAST_ADDR);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LATCH,
    S_ISSUE,
    S_WAIT,
    S_HALT
  } state_t;

  state_t              state_reg;
  logic [ADDR_W-1:0]   pc_reg;
  logic [DATA_W-1:0]   instr_reg;
  logic                run_reg;
  logic                halted_reg;

  // The current instruction retires in this cycle.
  logic                advance;
  logic [ADDR_W-1:0]   pc_next;
  logic                halt_next;

  assign advance  = ((state_reg == S_ISSUE) || (state_reg == S_WAIT)) && proc_done;
  assign mem_addr = pc_reg;
  assign pc       = pc_reg;
  assign instr    = instr_reg;
  assign run      = run_reg;
  assign halted   = halted_reg;

  // Next PC on retirement: a jump wins over both wrap and halt; an
  // out-of-range jump target simply keeps counting modulo 2**ADDR_W.
  always_comb begin
    pc_next   = pc_reg + 1'b1;
    halt_next = 1'b0;
    if (jump_en) begin
      pc_next = jump_addr;
    end else if (pc_reg == LAST_PC) begin
      if (WRAP != 0) begin
        pc_next = '0;
      end else begin
        pc_next   = pc_reg;
        halt_next = 1'b1;
      end
    end
  end

  // Sequencer FSM with registered outputs; run is set on the way into ISSUE so
  // it is high for exactly that cycle.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      pc_reg     <= '0;
      instr_reg  <= '0;
      run_reg    <= 1'b0;
      halted_reg <= 1'b0;
    end else begin
      run_reg <= 1'b0;
      case (state_reg)
        S_IDLE: begin
          if (enable) state_reg <= S_FETCH;
        end
        S_FETCH: begin
          state_reg <= S_LATCH;
        end
        S_LATCH: begin
          instr_reg <= mem_q;
          run_reg   <= 1'b1;
          state_reg <= S_ISSUE;
        end
        S_ISSUE, S_WAIT: begin
          if (advance) begin
            pc_reg <= pc_next;
            if (halt_next) begin
              state_reg  <= S_HALT;
              halted_reg <= 1'b1;
            end else if (enable) begin
              state_reg <= S_FETCH;
            end else begin
              state_reg <= S_IDLE;
            end
          end else begin
            state_reg <= S_WAIT;
          end
        end
        S_HALT: begin
          state_reg <= S_HALT;
        end
        default: begin
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

`ifdef INSTR_SEQUENCER_RETCNT_EN
  logic [15:0] ret_cnt_reg;

  assign ret_cnt = ret_cnt_reg;

  // Retired-instruction counter, sticks at all-ones instead of rolling over.
  always_ff @(posedge clock) begin
    if (reset) begin
      ret_cnt_reg <= '0;
    end else if (advance && (ret_cnt_reg != 16'hFFFF)) begin
      ret_cnt_reg <= ret_cnt_reg + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: dut_a uses the default wrap-around program space,
// dut_b halts after address 3. A transaction-level model (pc, fetched word,
// cycles since fetch, retire count) is stepped every cycle and compared with
// both DUTs; directed sections add literal expectations.
module tb_instr_sequencer;

  localparam int AW     = 5;
  localparam int DW     = 16;
  localparam int LAST_A = 31;
  localparam int LAST_B = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst     [2];
  logic          en      [2];
  logic          pd      [2];
  logic          je      [2];
  logic [AW-1:0] ja      [2];
  logic [AW-1:0] maddr   [2];
  logic [DW-1:0] mq      [2];
  logic [DW-1:0] instr_o [2];
  logic          run_o   [2];
  logic [AW-1:0] pc_o    [2];
  logic          halt_o  [2];
`ifdef INSTR_SEQUENCER_RETCNT_EN
  logic [15:0]   rc_o    [2];
`endif

  logic [DW-1:0] mem [32];

  // Synchronous instruction memory, one cycle of read latency.
  always @(posedge clk) begin
    mq[0] <= mem[maddr[0]];
    mq[1] <= mem[maddr[1]];
  end

  instr_sequencer #(.ADDR_W(AW), .DATA_W(DW)) dut_a (
    .clock     (clk),
    .reset     (rst[0]),
    .enable    (en[0]),
    .mem_addr  (maddr[0]),
    .mem_q     (mq[0]),
    .instr     (instr_o[0]),
    .run       (run_o[0]),
    .proc_done (pd[0]),
    .jump_en   (je[0]),
    .jump_addr (ja[0]),
    .pc        (pc_o[0]),
    .halted    (halt_o[0])
`ifdef INSTR_SEQUENCER_RETCNT_EN
    ,
    .ret_cnt   (rc_o[0])
`endif
  );

  instr_sequencer #(.ADDR_W(AW), .DATA_W(DW), .LAST_ADDR(LAST_B), .WRAP(0)) dut_b (
    .clock     (clk),
    .reset     (rst[1]),
    .enable    (en[1]),
    .mem_addr  (maddr[1]),
    .mem_q     (mq[1]),
    .instr     (instr_o[1]),
    .run       (run_o[1]),
    .proc_done (pd[1]),
    .jump_en   (je[1]),
    .jump_addr (ja[1]),
    .pc        (pc_o[1]),
    .halted    (halt_o[1])
`ifdef INSTR_SEQUENCER_RETCNT_EN
    ,
    .ret_cnt   (rc_o[1])
`endif
  );

  // Model state
  bit            m_busy  [2];
  int            m_age   [2];   // cycles since fetch began: 0 fetch, 1 latch, 2 issue, 3+ waiting
  bit            m_halt  [2];
  logic [AW-1:0] m_pc    [2];
  logic [DW-1:0] m_instr [2];
  int            m_cnt   [2];

  // Processor responder controls
  bit            auto_pd  [2];
  int            dly      [2];
  int            wcnt     [2];
  int            jmp_at   [2];
  logic [AW-1:0] jmp_to   [2];
  bit            force_pd [2];

  int vecs = 0;
  int errs = 0;

  function automatic int last_of(int i);
    return (i == 0) ? LAST_A : LAST_B;
  endfunction

  task automatic chk(input string nm, input int i, input logic [31:0] act, input logic [31:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s dut%0d: got %0h, want %0h", nm, i, act, exp);
    end
  endtask

  task automatic model_step(input int i);
    if (rst[i]) begin
      m_busy[i] = 1'b0; m_age[i] = 0; m_halt[i] = 1'b0;
      m_pc[i] = '0; m_instr[i] = '0; m_cnt[i] = 0;
    end else if (!m_halt[i]) begin
      if (!m_busy[i]) begin
        if (en[i]) begin m_busy[i] = 1'b1; m_age[i] = 0; end
      end else if (m_age[i] == 0) begin
        m_age[i] = 1;
      end else if (m_age[i] == 1) begin
        m_instr[i] = mem[m_pc[i]];
        m_age[i] = 2;
      end else if (pd[i]) begin
        if (m_cnt[i] < 65535) m_cnt[i]++;
        if (je[i]) begin
          m_pc[i] = ja[i];
          jmp_at[i] = -1;
        end else if (int'(m_pc[i]) == last_of(i)) begin
          if (i == 0) m_pc[i] = '0;
          else m_halt[i] = 1'b1;
        end else begin
          m_pc[i] = AW'((int'(m_pc[i]) + 1) % 32);
        end
        if (m_halt[i]) m_busy[i] = 1'b0;
        else begin m_busy[i] = en[i]; m_age[i] = 0; end
      end else begin
        m_age[i] = 3;
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      logic r;
      r = m_busy[i] && (m_age[i] == 2) && !m_halt[i];
      chk("pc", i, 32'(pc_o[i]), 32'(m_pc[i]));
      chk("mem_addr", i, 32'(maddr[i]), 32'(m_pc[i]));
      chk("instr", i, 32'(instr_o[i]), 32'(m_instr[i]));
      chk("run", i, 32'(run_o[i]), 32'(r));
      chk("halted", i, 32'(halt_o[i]), 32'(m_halt[i]));
`ifdef INSTR_SEQUENCER_RETCNT_EN
      chk("ret_cnt", i, 32'(rc_o[i]), 32'(m_cnt[i]));
`endif
    end
  endtask

  task automatic respond();
    for (int i = 0; i < 2; i++) begin
      if (m_busy[i] && (m_age[i] >= 2) && !m_halt[i]) begin
        if (m_age[i] == 2) wcnt[i] = dly[i];
        if (auto_pd[i] && (wcnt[i] == 0)) begin
          pd[i] = 1'b1;
          je[i] = (jmp_at[i] == int'(m_pc[i]));
          ja[i] = jmp_to[i];
        end else begin
          pd[i] = 1'b0; je[i] = 1'b0;
          if (wcnt[i] > 0) wcnt[i]--;
        end
      end else begin
        pd[i] = 1'b0; je[i] = 1'b0;
      end
      if (force_pd[i]) pd[i] = 1'b1;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    model_step(0);
    model_step(1);
    compare_all();
    respond();
  endtask

  task automatic wait_pc(input int i, input int v, input int budget, input string nm);
    int n = 0;
    while (pc_o[i] !== AW'(v) && n < budget) begin tick(); n++; end
    chk(nm, i, 32'(pc_o[i]), 32'(v));
  endtask

  task automatic wait_pc_change(input int i, input int budget, input string nm);
    logic [AW-1:0] p;
    int n = 0;
    p = pc_o[i];
    while (pc_o[i] === p && n < budget) begin tick(); n++; end
    chk(nm, i, 32'(n < budget), 32'(1));
  endtask

  task automatic wait_run(input int i, input int budget, input string nm);
    int n = 0;
    while (run_o[i] !== 1'b1 && n < budget) begin tick(); n++; end
    chk(nm, i, 32'(run_o[i]), 32'(1));
  endtask

  task automatic wait_halt(input int i, input int budget, input string nm);
    int n = 0;
    while (halt_o[i] !== 1'b1 && n < budget) begin tick(); n++; end
    chk(nm, i, 32'(halt_o[i]), 32'(1));
  endtask

  initial begin
    int runs;
    for (int a = 0; a < 32; a++) mem[a] = (a == 0) ? 16'h1234 : DW'(16'hA000 + a * 16'h0011);
    for (int i = 0; i < 2; i++) begin
      rst[i] = 1'b1; en[i] = 1'b0; pd[i] = 1'b0; je[i] = 1'b0; ja[i] = '0;
      auto_pd[i] = 1'b1; dly[i] = 0; wcnt[i] = 0; jmp_at[i] = -1; jmp_to[i] = '0;
      force_pd[i] = 1'b0;
    end
    tick();
    tick();
    chk("reset_pc", 0, 32'(pc_o[0]), 32'(0));
    chk("reset_run", 0, 32'(run_o[0]), 32'(0));
    chk("reset_halted", 0, 32'(halt_o[0]), 32'(0));
    chk("reset_instr", 0, 32'(instr_o[0]), 32'(0));

    // First instruction: run in cycle 3, done two cycles later
    rst[0] = 1'b0; en[0] = 1'b1; dly[0] = 2;
    tick(); chk("cyc1_run", 0, 32'(run_o[0]), 32'(0));
    tick(); chk("cyc2_run", 0, 32'(run_o[0]), 32'(0));
    tick(); chk("cyc3_run", 0, 32'(run_o[0]), 32'(1));
    chk("cyc3_instr", 0, 32'(instr_o[0]), 32'h1234);
    tick(); tick(); tick();
    chk("first_done_pc", 0, 32'(pc_o[0]), 32'(1));

    // Jump from pc 5 to 2
    dly[0] = 0; jmp_at[0] = 5; jmp_to[0] = 5'd2;
    wait_pc(0, 5, 60, "reach_pc5");
    wait_pc_change(0, 20, "leave_pc5");
    chk("jump_pc", 0, 32'(pc_o[0]), 32'(2));
    chk("jump_mem_addr", 0, 32'(maddr[0]), 32'(2));

    // Wrap from 31 to 0 and keep fetching
    wait_pc(0, 31, 400, "reach_pc31");
    wait_pc_change(0, 20, "leave_pc31");
    chk("wrap_pc", 0, 32'(pc_o[0]), 32'(0));
    chk("wrap_halted", 0, 32'(halt_o[0]), 32'(0));
    wait_run(0, 10, "wrap_run");
    chk("wrap_instr", 0, 32'(instr_o[0]), 32'h1234);

    // Ten completions, then enable dropped while waiting on the eleventh
    rst[0] = 1'b1; tick(); rst[0] = 1'b0; en[0] = 1'b1; dly[0] = 1;
    wait_pc(0, 10, 200, "ten_done");
`ifdef INSTR_SEQUENCER_RETCNT_EN
    chk("ret_cnt_10", 0, 32'(rc_o[0]), 32'(10));
`endif
    dly[0] = 3;
    wait_run(0, 10, "run_11th");
    tick();
    en[0] = 1'b0;
    wait_pc(0, 11, 20, "eleventh_done");
    for (int k = 0; k < 6; k++) begin
      tick();
      chk("idle_run", 0, 32'(run_o[0]), 32'(0));
      chk("idle_pc", 0, 32'(pc_o[0]), 32'(11));
    end
`ifdef INSTR_SEQUENCER_RETCNT_EN
    chk("ret_cnt_11", 0, 32'(rc_o[0]), 32'(11));
`endif

    // Reset while waiting at pc 7; proc_done at and after reset is ignored
    rst[0] = 1'b1; tick(); rst[0] = 1'b0; en[0] = 1'b1; dly[0] = 6;
    wait_pc(0, 7, 120, "reach_pc7");
    wait_run(0, 10, "run_pc7");
    tick(); tick();
    rst[0] = 1'b1; en[0] = 1'b0; pd[0] = 1'b1;
    tick();
    rst[0] = 1'b0;
    chk("rst_wait_pc", 0, 32'(pc_o[0]), 32'(0));
    chk("rst_wait_run", 0, 32'(run_o[0]), 32'(0));
    chk("rst_wait_halted", 0, 32'(halt_o[0]), 32'(0));
    force_pd[0] = 1'b1; pd[0] = 1'b1;
    tick(); tick();
    force_pd[0] = 1'b0;
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("late_done_pc", 0, 32'(pc_o[0]), 32'(0));
      chk("late_done_run", 0, 32'(run_o[0]), 32'(0));
    end

    // dut_b: out-of-range jump target keeps counting modulo 32, then halts at 3
    rst[1] = 1'b0; en[1] = 1'b1; dly[1] = 1; jmp_at[1] = 1; jmp_to[1] = 5'd6;
    wait_pc(1, 6, 40, "b_far_jump");
    wait_pc_change(1, 20, "b_leave_6");
    chk("b_far_next", 1, 32'(pc_o[1]), 32'(7));
    chk("b_far_halted", 1, 32'(halt_o[1]), 32'(0));
    wait_halt(1, 400, "b_halt_after_wrap");
    chk("b_halt_pc", 1, 32'(pc_o[1]), 32'(3));
    runs = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (run_o[1] === 1'b1) runs++;
    end
    chk("b_runs_after_halt", 1, 32'(runs), 32'(0));

    // Four completions from reset halt dut_b
    rst[1] = 1'b1; tick(); rst[1] = 1'b0;
    wait_halt(1, 60, "b_four_halt");
    chk("b_four_pc", 1, 32'(pc_o[1]), 32'(3));
`ifdef INSTR_SEQUENCER_RETCNT_EN
    chk("b_four_ret_cnt", 1, 32'(rc_o[1]), 32'(4));
`endif

    // Jump at the last address beats halt
    rst[1] = 1'b1; tick(); rst[1] = 1'b0; jmp_at[1] = 3; jmp_to[1] = 5'd2;
    wait_pc(1, 3, 40, "b_reach_last");
    wait_pc_change(1, 20, "b_leave_last");
    chk("b_jump_beats_halt_pc", 1, 32'(pc_o[1]), 32'(2));
    chk("b_jump_beats_halt", 1, 32'(halt_o[1]), 32'(0));
    wait_halt(1, 40, "b_halt_again");

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
